// File: rtl/cpu7_exu_ld_scb_pkg.sv
// Shared constants for the execute-stage load scoreboard.
// The defaults describe a 32-entry integer register file that tracks up to
// four outstanding loads.
package cpu7_exu_ld_scb_pkg;

    localparam int SCB_NREG  = 32;  // architectural integer registers, r0 reads zero
    localparam int SCB_IDW   = 5;   // register index width, 2**IDW == NREG
    localparam int SCB_DEPTH = 4;   // maximum outstanding loads (1..15)
    localparam int SCB_CW    = 4;   // counter width, holds 0..DEPTH

endpackage

// File: rtl/cpu7_exu_scb_pend.sv
// Pending-destination vector plus the one-entry delayed-clear register.
// A returning load is captured first and its pending bit is cleared one cycle
// later, which lines up with the register-file write in w. When a set and the
// delayed clear hit the same index, the set wins.
module cpu7_exu_scb_pend
    import cpu7_exu_ld_scb_pkg::*;
#(
    parameter int NREG = SCB_NREG,
    parameter int IDW  = SCB_IDW
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_set_vld,
    input  logic [IDW-1:0]  i_set_idx,
    input  logic            i_ret_vld,
    input  logic [IDW-1:0]  i_ret_idx,
    input  logic [IDW-1:0]  i_rd_idx_a,
    input  logic [IDW-1:0]  i_rd_idx_b,
    output logic            o_rd_pend_a,
    output logic            o_rd_pend_b,
    output logic [NREG-1:0] o_pend
);

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_nxt;
    logic            r_dclr_vld;
    logic [IDW-1:0]  r_dclr_idx;

    // Next pending vector: apply the delayed clear first so a same-index set overrides it.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_dclr_vld) begin
            w_pend_nxt[r_dclr_idx] = 1'b0;
        end else begin
            w_pend_nxt = r_pend;
        end
        if (i_set_vld) begin
            w_pend_nxt[i_set_idx] = 1'b1;
        end else begin
            w_pend_nxt[i_set_idx] = w_pend_nxt[i_set_idx];
        end
    end

    // Pending vector and delayed-clear capture; reset drops all tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend     <= '0;
            r_dclr_vld <= 1'b0;
            r_dclr_idx <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_dclr_vld <= i_ret_vld;
            r_dclr_idx <= i_ret_idx;
        end
    end

    assign o_rd_pend_a = r_pend[i_rd_idx_a];
    assign o_rd_pend_b = r_pend[i_rd_idx_b];
    assign o_pend      = r_pend;

endmodule

// File: rtl/cpu7_exu_ld_scb.sv
// Load scoreboard beside the execute control logic. It tracks each pending
// load destination so the d-stage candidate stalls only on a RAW/WAW hazard
// against an outstanding load, or when it is a load and the tracker is full.
// Hazards use registered state only, so a return never relieves a stall in
// the same cycle.
module cpu7_exu_ld_scb
    import cpu7_exu_ld_scb_pkg::*;
#(
    parameter int NREG  = SCB_NREG,
    parameter int IDW   = SCB_IDW,
    parameter int DEPTH = SCB_DEPTH,
    parameter int CW    = SCB_CW
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ecl_scb_vld_d,
    input  logic            ecl_scb_kill_d,
    input  logic            ecl_scb_load_d,
    input  logic [IDW-1:0]  ecl_scb_rs1_d,
    input  logic            ecl_scb_rs1_use_d,
    input  logic [IDW-1:0]  ecl_scb_rs2_d,
    input  logic            ecl_scb_rs2_use_d,
    input  logic [IDW-1:0]  ecl_scb_rd_d,
    input  logic            ecl_scb_wen_d,
    input  logic            lsu_scb_ret_vld_m,
    input  logic [IDW-1:0]  lsu_scb_ret_rd_m,
    output logic            scb_ecl_stall_d,
    output logic            scb_ecl_issue_d,
    output logic            scb_ecl_full,
    output logic [CW-1:0]   scb_ecl_cnt,
    output logic [NREG-1:0] scb_ecl_pending,
    output logic            scb_ecl_err
);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_full;
    logic            r_err;
    logic            w_full_nxt;
    logic            w_err_nxt;
    logic            w_rs1_pend;
    logic            w_rs2_pend;
    logic [NREG-1:0] w_pend;
    logic            w_raw;
    logic            w_waw;
    logic            w_cap;
    logic            w_live;
    logic            w_stall;
    logic            w_issue;
    logic            w_ld_issue;
    logic            w_underflow;
    logic            w_dec;
    logic            w_set_vld;

    // Hazard detection, issue decision and next counter/flag values.
    always_comb begin
        w_raw       = (ecl_scb_rs1_use_d & w_rs1_pend) | (ecl_scb_rs2_use_d & w_rs2_pend);
        w_waw       = ecl_scb_wen_d & w_pend[ecl_scb_rd_d];
        w_cap       = ecl_scb_load_d & r_full;
        // Gating with resetn keeps issue low while reset is held.
        w_live      = resetn & ecl_scb_vld_d & ~ecl_scb_kill_d;
        w_stall     = w_live & (w_raw | w_waw | w_cap);
        w_issue     = w_live & ~(w_raw | w_waw | w_cap);
        w_ld_issue  = w_issue & ecl_scb_load_d;
        w_set_vld   = w_ld_issue & ecl_scb_wen_d & (ecl_scb_rd_d != IDW'(0));
        // A return with nothing outstanding is an underflow: flag it, keep cnt from wrapping.
        w_underflow = lsu_scb_ret_vld_m & (r_cnt == CW'(0));
        w_dec       = lsu_scb_ret_vld_m & ~w_underflow;
        case ({w_ld_issue, w_dec})
            2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
            2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
            default: w_cnt_nxt = r_cnt;
        endcase
        w_full_nxt  = (w_cnt_nxt == CNT_FULL);
        w_err_nxt   = r_err | w_underflow;
    end

    // Outstanding-load counter, registered full flag and sticky underflow error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_full <= w_full_nxt;
            r_err  <= w_err_nxt;
        end
    end

    cpu7_exu_scb_pend #(
        .NREG (NREG),
        .IDW  (IDW)
    ) u_pend (
        .clk         (clk),
        .resetn      (resetn),
        .i_set_vld   (w_set_vld),
        .i_set_idx   (ecl_scb_rd_d),
        .i_ret_vld   (lsu_scb_ret_vld_m),
        .i_ret_idx   (lsu_scb_ret_rd_m),
        .i_rd_idx_a  (ecl_scb_rs1_d),
        .i_rd_idx_b  (ecl_scb_rs2_d),
        .o_rd_pend_a (w_rs1_pend),
        .o_rd_pend_b (w_rs2_pend),
        .o_pend      (w_pend)
    );

    assign scb_ecl_stall_d = w_stall;
    assign scb_ecl_issue_d = w_issue;
    assign scb_ecl_full    = r_full;
    assign scb_ecl_cnt     = r_cnt;
    assign scb_ecl_pending = w_pend;
    assign scb_ecl_err     = r_err;

endmodule

// File: tb/tb_cpu7_exu_ld_scb.sv
// Directed bench for the load scoreboard. A queue of outstanding load
// destinations is pushed on every expected load issue and popped to drive
// each return, and its size gives the expected outstanding count.
module tb_cpu7_exu_ld_scb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        vld, kill, load, u1, u2, wen, ret_vld;
    logic [4:0]  rs1, rs2, rd, ret_rd;
    logic        stall, issue, full, err;
    logic [3:0]  cnt;
    logic [31:0] pending;

    int   errors = 0;
    int   checks = 0;
    logic [4:0] q[$];

    cpu7_exu_ld_scb dut (
        .clk               (clk),
        .resetn            (resetn),
        .ecl_scb_vld_d     (vld),
        .ecl_scb_kill_d    (kill),
        .ecl_scb_load_d    (load),
        .ecl_scb_rs1_d     (rs1),
        .ecl_scb_rs1_use_d (u1),
        .ecl_scb_rs2_d     (rs2),
        .ecl_scb_rs2_use_d (u2),
        .ecl_scb_rd_d      (rd),
        .ecl_scb_wen_d     (wen),
        .lsu_scb_ret_vld_m (ret_vld),
        .lsu_scb_ret_rd_m  (ret_rd),
        .scb_ecl_stall_d   (stall),
        .scb_ecl_issue_d   (issue),
        .scb_ecl_full      (full),
        .scb_ecl_cnt       (cnt),
        .scb_ecl_pending   (pending),
        .scb_ecl_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        vld = 1'b0; kill = 1'b0; load = 1'b0; wen = 1'b0;
        u1 = 1'b0; u2 = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        ret_vld = 1'b0; ret_rd = 5'd0;
    endtask

    task automatic cand(input logic ld, input logic [4:0] d, input logic [4:0] s1,
                        input logic us1, input logic [4:0] s2, input logic us2);
        vld = 1'b1; kill = 1'b0; load = ld; rd = d; wen = 1'b1;
        rs1 = s1; u1 = us1; rs2 = s2; u2 = us2;
    endtask

    // Drive a return for the oldest outstanding load.
    task automatic ret_pop();
        ret_vld = 1'b1;
        ret_rd  = q.pop_front();
    endtask

    // Finish the current cycle: let the edge pass, sample state 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", cnt, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_err", err, 32'd0);
        chk("rst_full", full, 32'd0);
        resetn = 1'b1;
        tick();

        // RAW: load r5 in cycle 0, consumer r6 = r5 + r1 from cycle 1, return in cycle 4.
        cand(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("raw_ld_issue", issue, 32'd1);
        q.push_back(5'd5);
        tick();
        chk("raw_cnt1", cnt, q.size());
        chk("raw_pend5", pending, 32'h0000_0020);
        cand(1'b0, 5'd6, 5'd5, 1'b1, 5'd1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("raw_stall_c1_3", stall, 32'd1);
            chk("raw_noissue_c1_3", issue, 32'd0);
            tick();
        end
        ret_pop();
        @(negedge clk);
        chk("raw_stall_c4", stall, 32'd1);
        tick();
        ret_vld = 1'b0;
        chk("raw_cnt0", cnt, q.size());
        chk("raw_pend_held", pending, 32'h0000_0020);
        @(negedge clk);
        chk("raw_stall_c5", stall, 32'd1);
        tick();
        chk("raw_pend_clr", pending, 32'd0);
        @(negedge clk);
        chk("raw_issue_c6", issue, 32'd1);
        chk("raw_nostall_c6", stall, 32'd0);
        tick();
        idle();

        // Full: four loads fill the tracker.
        for (int r = 1; r <= 4; r++) begin
            cand(1'b1, 5'(r), 5'd0, 1'b0, 5'd0, 1'b0);
            @(negedge clk);
            chk("full_fill_issue", issue, 32'd1);
            q.push_back(5'(r));
            tick();
        end
        chk("full_cnt4", cnt, q.size());
        chk("full_flag", full, 32'd1);
        chk("full_pend", pending, 32'h0000_001E);
        cand(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("full_ld_stall", stall, 32'd1);
        tick();
        cand(1'b0, 5'd8, 5'd9, 1'b1, 5'd10, 1'b1);
        @(negedge clk);
        chk("full_add_issue", issue, 32'd1);
        chk("full_add_nostall", stall, 32'd0);
        tick();
        cand(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        ret_pop();
        @(negedge clk);
        chk("full_ret_same_cycle_stall", stall, 32'd1);
        tick();
        ret_vld = 1'b0;
        chk("full_cnt3", cnt, q.size());
        chk("full_released", full, 32'd0);
        @(negedge clk);
        chk("full_ld7_issue_t1", issue, 32'd1);
        q.push_back(5'd7);
        tick();
        chk("full_cnt_back4", cnt, q.size());
        idle();
        repeat (4) begin
            ret_pop();
            tick();
        end
        idle();
        tick();
        chk("drain1_cnt", cnt, q.size());
        chk("drain1_pend", pending, 32'd0);

        // Simultaneous issue and return with two loads outstanding.
        for (int r = 1; r <= 2; r++) begin
            cand(1'b1, 5'(r), 5'd0, 1'b0, 5'd0, 1'b0);
            q.push_back(5'(r));
            tick();
        end
        chk("sim_cnt2", cnt, q.size());
        cand(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
        ret_vld = 1'b1;
        ret_rd  = 5'd2;
        void'(q.pop_back());
        @(negedge clk);
        chk("sim_issue", issue, 32'd1);
        q.push_back(5'd3);
        tick();
        idle();
        chk("sim_cnt_stays2", cnt, q.size());
        chk("sim_pend_before_clr", pending, 32'h0000_000E);
        tick();
        chk("sim_pend_after_clr", pending, 32'h0000_000A);
        repeat (2) begin
            ret_pop();
            tick();
        end
        idle();
        tick();
        chk("drain2_cnt", cnt, q.size());
        chk("drain2_pend", pending, 32'd0);

        // Load to r0 takes a slot but marks nothing; r0 readers never stall.
        cand(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        q.push_back(5'd0);
        tick();
        chk("r0_cnt", cnt, q.size());
        chk("r0_pend", pending, 32'd0);
        cand(1'b0, 5'd6, 5'd0, 1'b1, 5'd0, 1'b1);
        @(negedge clk);
        chk("r0_consumer_issue", issue, 32'd1);
        tick();
        cand(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        q.push_back(5'd5);
        tick();
        chk("kill_pre_pend", pending, 32'h0000_0020);
        cand(1'b0, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0);
        kill = 1'b1;
        @(negedge clk);
        chk("kill_stall", stall, 32'd0);
        chk("kill_issue", issue, 32'd0);
        tick();
        idle();
        chk("kill_cnt", cnt, q.size());
        chk("kill_pend", pending, 32'h0000_0020);
        repeat (2) begin
            ret_pop();
            tick();
        end
        idle();
        tick();
        chk("drain3_cnt", cnt, 32'd0);
        chk("drain3_pend", pending, 32'd0);

        // Underflow: a return with nothing outstanding is flagged and sticks.
        ret_vld = 1'b1;
        ret_rd  = 5'd4;
        tick();
        idle();
        chk("uf_err", err, 32'd1);
        chk("uf_cnt", cnt, 32'd0);
        repeat (2) tick();
        chk("uf_err_sticky", err, 32'd1);

        // Asynchronous reset in the middle of traffic with three loads outstanding.
        for (int r = 1; r <= 3; r++) begin
            cand(1'b1, 5'(r), 5'd0, 1'b0, 5'd0, 1'b0);
            q.push_back(5'(r));
            tick();
        end
        chk("mid_cnt3", cnt, q.size());
        cand(1'b0, 5'd9, 5'd1, 1'b1, 5'd0, 1'b0);
        #2;
        chk("mid_pre_stall", stall, 32'd1);
        resetn = 1'b0;
        #1;
        q.delete();
        chk("arst_cnt", cnt, 32'd0);
        chk("arst_pend", pending, 32'd0);
        chk("arst_err", err, 32'd0);
        chk("arst_stall", stall, 32'd0);
        chk("arst_issue", issue, 32'd0);
        tick();
        resetn = 1'b1;
        cand(1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("post_rst_issue", issue, 32'd1);
        q.push_back(5'd4);
        tick();
        idle();
        chk("post_rst_cnt", cnt, q.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu7_exu_ld_scb.md
Name: cpu7_exu_ld_scb

Overview:
Parametrised load scoreboard for the execute control path. It replaces the blanket "stall from load dispatch until load data returns" scheme with per-register tracking of up to DEPTH outstanding loads. The decode-stage candidate stalls only on a RAW/WAW hazard against a pending load destination, or when a load is presented while the tracker is full. It sits beside the execute control logic: ecl presents the d-stage candidate, and the LSU reports m-stage returns.

Parameters:
NREG, 32, number of architectural integer registers (r0 hardwired zero)
IDW, 5, register index width (must satisfy 2**IDW == NREG)
DEPTH, 4, maximum outstanding loads (1..15)
CW, 4, counter width (must be >= clog2(DEPTH+1))

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ecl_scb_vld_d  in  1  candidate instruction valid in d
ecl_scb_kill_d  in  1  candidate killed (taken branch in e)
ecl_scb_load_d  in  1  candidate is a load
ecl_scb_rs1_d  in  IDW  source 1 index
ecl_scb_rs1_use_d  in  1  source 1 actually read
ecl_scb_rs2_d  in  IDW  source 2 index
ecl_scb_rs2_use_d  in  1  source 2 actually read
ecl_scb_rd_d  in  IDW  destination index
ecl_scb_wen_d  in  1  candidate writes rd
lsu_scb_ret_vld_m  in  1  a load returns data this cycle (m)
lsu_scb_ret_rd_m  in  IDW  returning load destination
scb_ecl_stall_d  out  1  hold candidate in d
scb_ecl_issue_d  out  1  candidate accepted this cycle
scb_ecl_full  out  1  count == DEPTH
scb_ecl_cnt  out  CW  outstanding load count
scb_ecl_pending  out  NREG  per-register pending bits
scb_ecl_err  out  1  sticky underflow error

Behaviour:
- Reset (resetn low, asynchronous): pending = 0, cnt = 0, delayed-clear register = invalid, err = 0. All outputs read 0 while in reset. Reset mid-operation discards all tracking; any in-flight returns after reset are counted as underflow.
- Hazard (combinational, from registered state only):
  - raw = (rs1_use & pending[rs1]) | (rs2_use & pending[rs2])
  - waw = wen & pending[rd]
  - cap = load & full
- stall_d = vld & ~kill & (raw | waw | cap).
- issue_d = vld & ~kill & ~stall_d.
- Issue of a load:
  - cnt increments at the end of the cycle.
  - pending[rd] is set when wen & (rd != 0).
  - A load to r0, or a load with wen = 0, occupies a count slot but sets no pending bit.
- Return at cycle t:
  - cnt decrements at the end of cycle t; the slot is free from t+1.
  - The destination is captured into a one-entry delayed-clear register.
  - pending[ret_rd] clears at the end of cycle t+1, matching the regfile write in w.
  - A RAW consumer therefore issues no earlier than t+2.
- Same-cycle issue and return: cnt unchanged.
- Same-index set and delayed clear in the same cycle: set wins. This cannot occur legally (WAW stalls) but must be deterministic.
- Full: uses registered cnt; a return in the same cycle does not relieve a load stall until the next cycle. Non-load candidates never stall on full.
- Underflow: a return with cnt == 0 sets err (sticky until reset), leaves cnt at 0, and still performs the delayed clear.
- Return to a non-pending index: clear is a no-op.
- Kill: a killed candidate neither stalls nor issues; state is unchanged by it.
- Overflow is impossible: issue is gated by full.

Decomposition:
- Shared header (common.vh): scoreboard width macros (DEPTH default, CW, IDW).
- Flops use the existing dffr_s cells, reset driven by ~resetn.
- One natural sub-module, cpu7_exu_scb_pend: holds the NREG pending vector plus the delayed-clear register, with set/clear ports and two read-index lookups.
- The counter, hazard logic and err flag stay in the top module.

Test Plan:
- Reset: assert resetn = 0 mid-traffic with cnt = 3 → cnt = 0, pending = 0, err = 0, stall = 0 asynchronously.
- RAW:
  - Cycle 0: load r5 issues.
  - Cycle 1: add r6 = r5 + r1 presented.
  - Cycle 4: return r5.
  - Required: stall = 1 in cycles 1–5, issue = 1 in cycle 6; cnt 1 → 0 after cycle 4; pending[5] clears after cycle 5.
- Full (DEPTH = 4):
  - Loads to r1..r4 back-to-back → cnt = 4, full = 1.
  - A load to r7 then stalls, while a non-hazard add r8 = r9 + r10 issues.
  - Return r1 at cycle t → load r7 issues at t+1.
- Simultaneous issue and return: load r3 issues while r2 returns, with cnt = 2 → cnt stays 2; pending[3] = 1, pending[2] clears one cycle later.
- r0 and kill:
  - Load to r0 → cnt +1, pending stays 0, consumer reading r0 is not stalled.
  - Killed candidate reading pending r5 → stall = 0, issue = 0.
- Underflow: return r4 with cnt = 0 → err = 1 and stays set, cnt stays 0.
